// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory-unit port between NUM_REQ requesters.
// Commands are registered; read responses are steered back by a tag pipeline matched to READ_LATENCY.
module mem_port_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_hold,
    input  logic [2*NUM_REQ-1:0]      i_req_op,
    input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ack,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic [1:0]                o_mem_op,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_data,
    input  logic [DATA_W-1:0]         i_mem_data,
    output logic                      o_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

    // Requester index visited at the given step after the last winner.
    function automatic int cand_of(input logic [IDX_W-1:0] last, input int step);
        int c;
        c = int'(last) + step;
        if (c >= NUM_REQ) c = c - NUM_REQ;
        return c;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              grant;
    logic [1:0]        win_op;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    logic [IDX_W-1:0]        cmd_idx_p0;
    logic [READ_LATENCY-1:0] tag_vld_p;
    logic [IDX_W-1:0]        tag_idx_p [READ_LATENCY];

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!win_found && op_valid(i_req_op[2*cand_of(r_last, i) +: 2])) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand_of(r_last, i));
            end
        end
    end

    assign grant    = win_found & ~i_hold;
    assign win_op   = i_req_op[2*int'(win_idx) +: 2];
    assign win_addr = i_req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
    assign win_data = i_req_data[DATA_W*int'(win_idx) +: DATA_W];

    always_comb begin
        o_req_ack = '0;
        if (grant) o_req_ack = onehot(win_idx);
    end

    // Command stage: accepted op is presented to memory for exactly one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last     <= IDX_W'(NUM_REQ - 1);
            o_mem_op   <= OP_NOP;
            o_mem_addr <= '0;
            o_mem_data <= '0;
            cmd_idx_p0 <= '0;
        end else if (grant) begin
            r_last     <= win_idx;
            o_mem_op   <= win_op;
            o_mem_addr <= win_addr;
            o_mem_data <= win_data;
            cmd_idx_p0 <= win_idx;
        end else begin
            o_mem_op   <= OP_NOP;
        end
    end

    // Tag pipeline: the last stage lines up with the cycle memory returns read data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_vld_p <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_idx_p[i] <= '0;
        end else begin
            tag_vld_p[0] <= (o_mem_op == OP_READ);
            tag_idx_p[0] <= cmd_idx_p0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_idx_p[i] <= tag_idx_p[i-1];
            end
        end
    end

    // Response stage: capture memory data and route it to the issuing requester.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else if (tag_vld_p[READ_LATENCY-1]) begin
            o_rsp_valid <= onehot(tag_idx_p[READ_LATENCY-1]);
            o_rsp_data  <= i_mem_data;
        end else begin
            o_rsp_valid <= '0;
        end
    end

    assign o_busy = (o_mem_op == OP_READ) | (|tag_vld_p);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// A second instance with READ_LATENCY=3 covers the long-latency path.
module tb_mem_port_arbiter;

    localparam int N   = 4;
    localparam int AW  = 13;
    localparam int DW  = 64;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic [2*N-1:0]  req_op;
    logic [AW*N-1:0] req_addr;
    logic [DW*N-1:0] req_data;

    logic [N-1:0]  ack, rsp_valid, ack3, rsp_valid3;
    logic [DW-1:0] rsp_data, mem_data, mem_rdata, rsp_data3, mem_data3, mem_rdata3;
    logic [1:0]    mem_op, mem_op3;
    logic [AW-1:0] mem_addr, mem_addr3;
    logic          busy, busy3;

    logic [63:0] mem1 [0:8191];
    logic [63:0] mem3 [0:8191];
    logic [63:0] p3 [3];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          due;
        int          idx;
        logic [63:0] data;
    } rsp_t;
    rsp_t q[$];
    logic [63:0] ref_w [int];

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_hold(hold),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ack(ack), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
        .o_mem_op(mem_op), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
        .i_mem_data(mem_rdata), .o_busy(busy)
    );

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_hold(hold),
        .i_req_op(req_op), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ack(ack3), .o_rsp_valid(rsp_valid3), .o_rsp_data(rsp_data3),
        .o_mem_op(mem_op3), .o_mem_addr(mem_addr3), .o_mem_data(mem_data3),
        .i_mem_data(mem_rdata3), .o_busy(busy3)
    );

    // Memory unit models; non-read cycles return a junk pattern so misaligned sampling shows up.
    always @(posedge clk) begin
        if (mem_op == 2'd2) mem1[mem_addr] <= mem_data;
        mem_rdata <= (mem_op == 2'd1) ? mem1[mem_addr] : 64'h0BAD_0BAD_0BAD_0BAD;
    end

    always @(posedge clk) begin
        if (mem_op3 == 2'd2) mem3[mem_addr3] <= mem_data3;
        p3[0] <= (mem_op3 == 2'd1) ? mem3[mem_addr3] : 64'h0BAD_0BAD_0BAD_0BAD;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata3 = p3[2];

    function automatic logic [63:0] init_val(input int a);
        return 64'hC0DE_0000_0000_0000 | 64'(a);
    endfunction

    task automatic set_req(input int k, input logic [1:0] op, input logic [12:0] a, input logic [63:0] d);
        req_op[2*k +: 2]     = op;
        req_addr[AW*k +: AW] = a;
        req_data[DW*k +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_op   = '0;
        req_addr = '0;
        req_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        hold = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (mem_op !== 2'd0) begin failures++; $display("FAIL rst_mem_op got=%0d exp=0", mem_op); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_data !== '0) begin failures++; $display("FAIL rst_mem_data got=%h exp=0", mem_data); end
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin failures++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (ack !== '0) begin failures++; $display("FAIL rst_ack got=%b exp=0", ack); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL rst_busy3 got=%b exp=0", busy3); end
        @(negedge clk);
    endtask

    task automatic test_alternating_reads();
        logic [N-1:0] e;
        do_reset();
        set_req(0, 2'd1, 13'h010, 64'h0);
        set_req(2, 2'd1, 13'h020, 64'h0);
        for (int n = 0; n < 10; n++) begin
            #1;
            e = (n % 2 == 0) ? 4'b0001 : 4'b0100;
            checks++; if (ack !== e) begin failures++; $display("FAIL alt_ack n=%0d got=%b exp=%b", n, ack, e); end
            if (n >= 1) begin
                checks++; if (mem_op !== 2'd1 || mem_addr !== (((n-1) % 2 == 0) ? 13'h010 : 13'h020)) begin
                    failures++; $display("FAIL alt_cmd n=%0d got op=%0d addr=%h", n, mem_op, mem_addr);
                end
            end
            if (n >= 3) begin
                e = ((n-3) % 2 == 0) ? 4'b0001 : 4'b0100;
                checks++; if (rsp_valid !== e || rsp_data !== init_val(((n-3) % 2 == 0) ? 'h010 : 'h020)) begin
                    failures++; $display("FAIL alt_rsp n=%0d got v=%b d=%h exp v=%b", n, rsp_valid, rsp_data, e);
                end
            end else begin
                checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL alt_rsp_early n=%0d got=%b exp=0", n, rsp_valid); end
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_write_readback();
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 2'd2, 13'(k), 64'hA5A5_0000_0000_0000 | 64'(k));
        for (int n = 0; n < 6; n++) begin
            #1;
            checks++; if (ack !== ((n < 4) ? 4'(1 << n) : 4'b0)) begin
                failures++; $display("FAIL wr_ack n=%0d got=%b exp=%b", n, ack, (n < 4) ? 4'(1 << n) : 4'b0);
            end
            if (n >= 1 && n <= 4) begin
                checks++; if (mem_op !== 2'd2 || mem_addr !== 13'(n-1) || mem_data !== (64'hA5A5_0000_0000_0000 | 64'(n-1))) begin
                    failures++; $display("FAIL wr_cmd n=%0d got op=%0d addr=%h data=%h", n, mem_op, mem_addr, mem_data);
                end
            end else if (n == 5) begin
                checks++; if (mem_op !== 2'd0) begin failures++; $display("FAIL wr_idle got=%0d exp=0", mem_op); end
            end
            @(negedge clk);
            if (n < 4) set_req(n, 2'd0, 13'h0, 64'h0);
        end
        for (int j = 0; j < 7; j++) begin
            if (j < 4) set_req(0, 2'd1, 13'(j), 64'h0);
            else set_req(0, 2'd0, 13'h0, 64'h0);
            #1;
            if (j < 4) begin
                checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL rb_ack j=%0d got=%b exp=0001", j, ack); end
            end
            if (j >= 3) begin
                checks++; if (rsp_valid !== 4'b0001 || rsp_data !== (64'hA5A5_0000_0000_0000 | 64'(j-3))) begin
                    failures++; $display("FAIL rb_rsp j=%0d got v=%b d=%h exp d=%h", j, rsp_valid, rsp_data, 64'hA5A5_0000_0000_0000 | 64'(j-3));
                end
            end else begin
                checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL rb_rsp_early j=%0d got=%b exp=0", j, rsp_valid); end
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_latency3();
        do_reset();
        set_req(1, 2'd1, 13'h1FFF, 64'h0);
        #1;
        checks++; if (ack3 !== 4'b0010) begin failures++; $display("FAIL l3_ack got=%b exp=0010", ack3); end
        @(negedge clk);
        clear_reqs();
        for (int n = 1; n <= 7; n++) begin
            #1;
            if (n == 1) begin
                checks++; if (mem_op3 !== 2'd1 || mem_addr3 !== 13'h1FFF) begin
                    failures++; $display("FAIL l3_cmd got op=%0d addr=%h exp op=1 addr=1fff", mem_op3, mem_addr3);
                end
            end
            if (n <= 4) begin
                checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL l3_busy n=%0d got=%b exp=1", n, busy3); end
            end
            if (n >= 6) begin
                checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL l3_idle n=%0d got=%b exp=0", n, busy3); end
            end
            checks++; if (rsp_valid3 !== ((n == 5) ? 4'b0010 : 4'b0000)) begin
                failures++; $display("FAIL l3_rsp_valid n=%0d got=%b", n, rsp_valid3);
            end
            if (n == 5) begin
                checks++; if (rsp_data3 !== init_val('h1FFF)) begin
                    failures++; $display("FAIL l3_rsp_data got=%h exp=%h", rsp_data3, init_val('h1FFF));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        do_reset();
        hold = 1'b1;
        set_req(3, 2'd1, 13'h0AB, 64'h0);
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++; if (ack !== '0) begin failures++; $display("FAIL hold_ack n=%0d got=%b exp=0", n, ack); end
            checks++; if (mem_op !== 2'd0) begin failures++; $display("FAIL hold_op n=%0d got=%0d exp=0", n, mem_op); end
            @(negedge clk);
        end
        hold = 1'b0;
        #1;
        checks++; if (ack !== 4'b1000) begin failures++; $display("FAIL hold_release_ack got=%b exp=1000", ack); end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++; if (mem_op !== 2'd1 || mem_addr !== 13'h0AB) begin
            failures++; $display("FAIL hold_release_cmd got op=%0d addr=%h exp op=1 addr=0ab", mem_op, mem_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_req(0, 2'd1, 13'h030, 64'h0);
        set_req(1, 2'd1, 13'h031, 64'h0);
        #1;
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL ar_ack0 got=%b exp=0001", ack); end
        @(negedge clk);
        #1;
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL ar_ack1 got=%b exp=0010", ack); end
        @(negedge clk);
        clear_reqs();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_op !== 2'd0 || mem_addr !== '0 || mem_data !== '0) begin
            failures++; $display("FAIL ar_cmd got op=%0d addr=%h data=%h exp zeros", mem_op, mem_addr, mem_data);
        end
        checks++; if (busy !== 1'b0 || busy3 !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b/%b exp=0", busy, busy3); end
        checks++; if (rsp_valid !== '0) begin failures++; $display("FAIL ar_rsp_valid got=%b exp=0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            #1;
            checks++; if (rsp_valid !== '0 || rsp_valid3 !== '0) begin
                failures++; $display("FAIL ar_ghost n=%0d got=%b/%b exp=0", n, rsp_valid, rsp_valid3);
            end
            @(negedge clk);
        end
        set_req(0, 2'd1, 13'h040, 64'h0);
        set_req(2, 2'd1, 13'h041, 64'h0);
        #1;
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL ar_first_grant got=%b exp=0001", ack); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_reserved_op();
        do_reset();
        set_req(0, 2'd3, 13'h055, 64'h1234);
        set_req(1, 2'd0, 13'h066, 64'h0);
        for (int n = 0; n < 4; n++) begin
            #1;
            checks++; if (ack !== '0) begin failures++; $display("FAIL rsv_ack n=%0d got=%b exp=0", n, ack); end
            checks++; if (mem_op !== 2'd0) begin failures++; $display("FAIL rsv_op n=%0d got=%0d exp=0", n, mem_op); end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_random();
        int          last;
        int          w;
        logic [1:0]  e_op, op;
        logic [12:0] e_addr;
        logic [63:0] e_data, e_rd, rv;
        logic [N-1:0] e_rv, e_ack;
        logic        e_busy;
        last = N - 1; e_op = 2'd0; e_addr = '0; e_data = '0; e_rd = '0;
        q.delete();
        do_reset();
        for (int t = 0; t < 500; t++) begin
            e_rv = '0;
            if (q.size() > 0 && q[0].due == t) begin
                e_rv = 4'(1 << q[0].idx);
                e_rd = q[0].data;
                void'(q.pop_front());
            end
            e_busy = 1'b0;
            foreach (q[j]) if (q[j].due - LAT - 1 <= t) e_busy = 1'b1;
            #1;
            checks++; if (mem_op !== e_op) begin failures++; $display("FAIL rnd_op t=%0d got=%0d exp=%0d", t, mem_op, e_op); end
            checks++; if (mem_addr !== e_addr) begin failures++; $display("FAIL rnd_addr t=%0d got=%h exp=%h", t, mem_addr, e_addr); end
            checks++; if (mem_data !== e_data) begin failures++; $display("FAIL rnd_data t=%0d got=%h exp=%h", t, mem_data, e_data); end
            checks++; if (rsp_valid !== e_rv) begin failures++; $display("FAIL rnd_rsp_valid t=%0d got=%b exp=%b", t, rsp_valid, e_rv); end
            checks++; if (rsp_data !== e_rd) begin failures++; $display("FAIL rnd_rsp_data t=%0d got=%h exp=%h", t, rsp_data, e_rd); end
            checks++; if (busy !== e_busy) begin failures++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, busy, e_busy); end
            hold = ($urandom_range(0, 5) == 0);
            for (int k = 0; k < N; k++)
                set_req(k, 2'($urandom_range(0, 3)), 13'(13'h100 + $urandom_range(0, 15)), {$urandom, $urandom});
            #1;
            w = -1;
            if (!hold) begin
                for (int i = 1; i <= N; i++) begin
                    int c;
                    c  = (last + i) % N;
                    op = req_op[2*c +: 2];
                    if (w < 0 && (op == 2'd1 || op == 2'd2)) w = c;
                end
            end
            e_ack = (w >= 0) ? 4'(1 << w) : 4'b0;
            checks++; if (ack !== e_ack) begin failures++; $display("FAIL rnd_ack t=%0d got=%b exp=%b", t, ack, e_ack); end
            if (w >= 0) begin
                last   = w;
                e_op   = req_op[2*w +: 2];
                e_addr = req_addr[AW*w +: AW];
                e_data = req_data[DW*w +: DW];
                if (e_op == 2'd2) ref_w[int'(e_addr)] = e_data;
                else begin
                    rv = ref_w.exists(int'(e_addr)) ? ref_w[int'(e_addr)] : init_val(int'(e_addr));
                    q.push_back('{t + LAT + 2, w, rv});
                end
            end else begin
                e_op = 2'd0;
            end
            @(negedge clk);
        end
        hold = 1'b0;
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        for (int a = 0; a < 8192; a++) begin
            mem1[a] = init_val(a);
            mem3[a] = init_val(a);
        end
        test_reset();
        test_alternating_reads();
        test_write_readback();
        test_latency3();
        test_hold();
        test_async_reset();
        test_reserved_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
